// File: rtl/button_ctrl_pkg.sv
// button_pkg: shared definitions for the button_ctrl slice.
//   - event code values carried on evt_code
//   - per-channel FSM state type
//   - id_width(): width of the event id field for a given button count
package button_pkg;

    localparam logic [1:0] EVT_NONE    = 2'd0;
    localparam logic [1:0] EVT_PRESS   = 2'd1;
    localparam logic [1:0] EVT_RELEASE = 2'd2;
    localparam logic [1:0] EVT_LONG    = 2'd3;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } btn_state_t;

    // A single button still needs a 1-bit id field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// button_ctrl_if: valid/ready event port of button_ctrl.
//   evt_valid  event available (producer -> consumer)
//   evt_ready  consumer accepts the event
//   evt_id     source button index
//   evt_code   EVT_PRESS / EVT_RELEASE / EVT_LONG
// Modports: master (event producer), slave (event consumer).
interface button_ctrl_if #(
    parameter int unsigned NB_BUTTONS = 4
);
    import button_pkg::*;

    localparam int unsigned ID_W = id_width(NB_BUTTONS);

    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [1:0]      evt_code;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_code,
        output evt_ready
    );

endinterface

// File: rtl/button_chan.sv
// button_chan: one button channel of button_ctrl.
//   clk, rst   system clock, asynchronous active-high reset
//   tick       1 ms pulse from the shared prescaler
//   raw        raw asynchronous button level (1 = pressed)
//   grant_clr  arbiter took this channel's pending event
//   pending    an event is waiting in the one-entry slot
//   code       event code held in the slot
//   level      debounced button level
//   ovf_set    a pending event is being overwritten this cycle
// BUTTON_CTRL_LONG_PRESS_EN: adds the HELD state, hold counter and LONG event.
module button_chan
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_PER_MS = 20,
    parameter int unsigned LONG_PRESS_MS   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       raw,
    input  logic       grant_clr,
    output logic       pending,
    output logic [1:0] code,
    output logic       level,
    output logic       ovf_set
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_PER_MS + 1);

    logic            sync1, sync2;
    logic [DB_W-1:0] db_cnt;
    logic            flip;

    btn_state_t      state, state_nxt;
    logic            ev_new;
    logic [1:0]      ev_new_code;
    logic            ev_pulse;
    logic [1:0]      ev_code;

    // The level flips on the tick that would bring the counter to
    // DEBOUNCE_PER_MS; the FSM sees the flip combinationally so that
    // level and state update on the same edge.
    assign flip = (sync2 != level) && tick && (db_cnt == DB_W'(DEBOUNCE_PER_MS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                db_cnt <= '0;
                level  <= ~level;
            end else if (tick) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef BUTTON_CTRL_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_MS + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_hit;

    assign long_hit = tick && (hold_cnt == HOLD_W'(LONG_PRESS_MS - 1));

    // Counts ticks only while in PRESSED; leaving PRESSED restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != ST_PRESSED) begin
            hold_cnt <= '0;
        end else if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RELEASED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ev_new      = 1'b0;
        ev_new_code = EVT_NONE;
        case (state)
            ST_RELEASED: begin
                if (flip) begin
                    state_nxt   = ST_PRESSED;
                    ev_new      = 1'b1;
                    ev_new_code = EVT_PRESS;
                end
            end
            ST_PRESSED: begin
                if (flip) begin
                    state_nxt   = ST_RELEASED;
                    ev_new      = 1'b1;
                    ev_new_code = EVT_RELEASE;
                end
`ifdef BUTTON_CTRL_LONG_PRESS_EN
                else if (long_hit) begin
                    state_nxt   = ST_HELD;
                    ev_new      = 1'b1;
                    ev_new_code = EVT_LONG;
                end
`endif
            end
`ifdef BUTTON_CTRL_LONG_PRESS_EN
            ST_HELD: begin
                if (flip) begin
                    state_nxt   = ST_RELEASED;
                    ev_new      = 1'b1;
                    ev_new_code = EVT_RELEASE;
                end
            end
`endif
            default: begin
                state_nxt = ST_RELEASED;
            end
        endcase
    end

    // A new event wins over a same-cycle grant clear, so it stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_pulse <= 1'b0;
            ev_code  <= EVT_NONE;
            pending  <= 1'b0;
            code     <= EVT_NONE;
        end else begin
            ev_pulse <= ev_new;
            ev_code  <= ev_new_code;
            if (ev_pulse) begin
                pending <= 1'b1;
                code    <= ev_code;
            end else if (grant_clr) begin
                pending <= 1'b0;
                code    <= EVT_NONE;
            end
        end
    end

    assign ovf_set = ev_pulse && pending && !grant_clr;

endmodule

// File: rtl/button_ctrl.sv
// button_ctrl: multi-button front end.
//   clk, rst      system clock, asynchronous active-high reset
//   button_in     raw button levels (1 = pressed)
//   button_state  debounced levels
//   evt           event port (button_ctrl_if.master): evt_valid/evt_ready/evt_id/evt_code
//   evt_ovf       sticky per-channel "event lost" flags
//   ovf_clr       clears evt_ovf (a same-cycle new overflow still sets)
// Shared 1 ms prescaler, NB_BUTTONS button_chan instances, round-robin
// arbiter and the output event register.
// BUTTON_CTRL_LONG_PRESS_EN: enables LONG events in every channel.
module button_ctrl
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 95_000,
    parameter int unsigned DEBOUNCE_PER_MS = 20,
    parameter int unsigned LONG_PRESS_MS   = 1000,
    parameter int unsigned NB_BUTTONS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_BUTTONS-1:0] button_in,
    output logic [NB_BUTTONS-1:0] button_state,
    button_ctrl_if.master         evt,
    output logic [NB_BUTTONS-1:0] evt_ovf,
    input  logic                  ovf_clr
);

    localparam int unsigned ID_W = id_width(NB_BUTTONS);
    localparam int unsigned PS_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

    logic [PS_W-1:0]       presc;
    logic                  tick;
    logic [NB_BUTTONS-1:0] pending, grant_clr, ovf_set;
    logic [1:0]            chan_code [NB_BUTTONS];
    logic [ID_W-1:0]       last_grant, grant_idx, cand;
    logic                  grant_found, load_en;

    assign tick = (presc == PS_W'(CLK_FREQ - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < NB_BUTTONS; i++) begin : g_chan
        button_chan #(
            .DEBOUNCE_PER_MS (DEBOUNCE_PER_MS),
            .LONG_PRESS_MS   (LONG_PRESS_MS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .raw       (button_in[i]),
            .grant_clr (grant_clr[i]),
            .pending   (pending[i]),
            .code      (chan_code[i]),
            .level     (button_state[i]),
            .ovf_set   (ovf_set[i])
        );
    end

    // Search starts one past the last grant and wraps, so the last granted
    // channel is considered last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NB_BUTTONS; k++) begin
            cand = ID_W'((32'(last_grant) + k) % NB_BUTTONS);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign load_en = !evt.evt_valid || evt.evt_ready;

    always_comb begin
        grant_clr = '0;
        if (load_en && grant_found) begin
            grant_clr[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_id    <= '0;
            evt.evt_code  <= EVT_NONE;
            last_grant    <= ID_W'(NB_BUTTONS - 1);
        end else if (load_en) begin
            if (grant_found) begin
                evt.evt_valid <= 1'b1;
                evt.evt_id    <= grant_idx;
                evt.evt_code  <= chan_code[grant_idx];
                last_grant    <= grant_idx;
            end else begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_ovf <= '0;
        end else begin
            evt_ovf <= (ovf_clr ? '0 : evt_ovf) | ovf_set;
        end
    end

endmodule
